instruction_fetch_unit: RTL and testbench

RV32IM instruction-fetch stage: owns the program counter, issues word reads to instruction memory under a busywait handshake, and presents `{pc, pc_plus_4, instruction, fetch_valid}` to the IF/ID pipeline register directly downstream. It honours pipeline stall from the hazard unit and redirects fetch on a taken branch/jump from EX. An in-flight memory read is always completed and discarded on redirect, never aborted.

---
 rtl/instruction_fetch_unit_if.sv | 22 ++
 rtl/instruction_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instruction_fetch_unit.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_unit_if.sv
// Instruction memory port bundle.
// The fetch unit is the master and the memory is the slave.
interface instruction_fetch_unit_if;
  logic        imem_read;
  logic [31:0] imem_address;
  logic [31:0] imem_readdata;
  logic        imem_busywait;

  modport master (
    output imem_read,
    output imem_address,
    input  imem_readdata,
    input  imem_busywait
  );

  modport slave (
    input  imem_read,
    input  imem_address,
    output imem_readdata,
    output imem_busywait
  );
endinterface

// File: rtl/instruction_fetch_unit.sv
// RV32IM fetch stage: PC, busywait memory reads, stall hold buffer,
// and branch redirect with drain of an in-flight read.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           stall,
  input  logic                           branch_taken,
  input  logic [31:0]                    branch_target,
  instruction_fetch_unit_if.master       imem,
  output logic [31:0]                    pc,
  output logic [31:0]                    pc_plus_4,
  output logic [31:0]                    instruction,
  output logic                           fetch_valid
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD,
    DRAIN
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc_reg, pc_reg_n;
  logic [31:0] redirect_target, redirect_target_n;
  logic [31:0] buf_instr, buf_instr_n;
  logic [31:0] buf_pc, buf_pc_n;
  logic [31:0] pc_n, pc_plus_4_n, instruction_n;
  logic        fetch_valid_n;
  logic        complete;
  logic [31:0] target;

  assign target            = branch_target & ~32'h3;
  assign imem.imem_read    = (state == FETCH) || (state == DRAIN);
  assign imem.imem_address = pc_reg;
  assign complete          = imem.imem_read && !imem.imem_busywait;

  always_comb begin
    state_n           = state;
    pc_reg_n          = pc_reg;
    redirect_target_n = redirect_target;
    buf_instr_n       = buf_instr;
    buf_pc_n          = buf_pc;
    pc_n              = pc;
    pc_plus_4_n       = pc_plus_4;
    instruction_n     = instruction;
    fetch_valid_n     = fetch_valid;

    // Any output load without a fresh instruction is a bubble.
    if (!stall || branch_taken) begin
      instruction_n = NOP_INSTR;
      fetch_valid_n = 1'b0;
    end

    unique case (state)
      IDLE: begin
        state_n = FETCH;
        if (branch_taken) pc_reg_n = target;
      end
      FETCH: begin
        if (branch_taken) begin
          if (complete) begin
            pc_reg_n = target;
          end else begin
            redirect_target_n = target;
            state_n           = DRAIN;
          end
        end else if (complete) begin
          pc_reg_n = pc_reg + 32'd4;
          if (!stall) begin
            pc_n          = pc_reg;
            pc_plus_4_n   = pc_reg + 32'd4;
            instruction_n = imem.imem_readdata;
            fetch_valid_n = 1'b1;
          end else begin
            buf_instr_n = imem.imem_readdata;
            buf_pc_n    = pc_reg;
            state_n     = HOLD;
          end
        end
      end
      HOLD: begin
        if (branch_taken) begin
          pc_reg_n = target;
          state_n  = FETCH;
        end else if (!stall) begin
          pc_n          = buf_pc;
          pc_plus_4_n   = buf_pc + 32'd4;
          instruction_n = buf_instr;
          fetch_valid_n = 1'b1;
          state_n       = FETCH;
        end
      end
      DRAIN: begin
        if (complete) begin
          pc_reg_n = branch_taken ? target : redirect_target;
          state_n  = FETCH;
        end else if (branch_taken) begin
          redirect_target_n = target;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= IDLE;
      pc_reg          <= RESET_PC;
      redirect_target <= 32'h0;
      buf_instr       <= NOP_INSTR;
      buf_pc          <= 32'h0;
      pc              <= 32'h0;
      pc_plus_4       <= 32'h0;
      instruction     <= NOP_INSTR;
      fetch_valid     <= 1'b0;
    end else begin
      state           <= state_n;
      pc_reg          <= pc_reg_n;
      redirect_target <= redirect_target_n;
      buf_instr       <= buf_instr_n;
      buf_pc          <= buf_pc_n;
      pc              <= pc_n;
      pc_plus_4       <= pc_plus_4_n;
      instruction     <= instruction_n;
      fetch_valid     <= fetch_valid_n;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; memory returns addr ^ 0xA5A5_0000.
// A second instance exercises PC wrap-around from a high reset PC.
module tb_instruction_fetch_unit;

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [31:0] KEY = 32'hA5A5_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic        busy = 1'b0;
  logic [31:0] pc, pc_plus_4, instruction;
  logic        fetch_valid;

  logic        reset2 = 1'b1;
  logic [31:0] pc2, pc_plus_4_2, instruction2;
  logic        fetch_valid2;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instruction_fetch_unit_if bus ();
  instruction_fetch_unit_if bus2 ();

  assign bus.imem_readdata  = bus.imem_address ^ KEY;
  assign bus.imem_busywait  = busy;
  assign bus2.imem_readdata = bus2.imem_address ^ KEY;
  assign bus2.imem_busywait = 1'b0;

  instruction_fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem(bus.master), .pc(pc), .pc_plus_4(pc_plus_4),
    .instruction(instruction), .fetch_valid(fetch_valid)
  );

  instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .reset(reset2), .stall(1'b0),
    .branch_taken(1'b0), .branch_target(32'h0),
    .imem(bus2.master), .pc(pc2), .pc_plus_4(pc_plus_4_2),
    .instruction(instruction2), .fetch_valid(fetch_valid2)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Checks a presented-instruction snapshot of the main instance.
  task automatic expect_out(string name, logic [31:0] epc, logic ev);
    logic [31:0] ei;
    ei = ev ? (epc ^ KEY) : NOP;
    checks++;
    if (fetch_valid !== ev) begin
      errors++;
      $display("FAIL %s valid got %b exp %b", name, fetch_valid, ev);
    end
    checks++;
    if (pc !== epc || pc_plus_4 !== epc + 32'd4) begin
      errors++;
      $display("FAIL %s pc got %h/%h exp %h/%h", name, pc, pc_plus_4, epc, epc + 32'd4);
    end
    checks++;
    if (instruction !== ei) begin
      errors++;
      $display("FAIL %s instr got %h exp %h", name, instruction, ei);
    end
  endtask

  task automatic expect_req(string name, logic er, logic [31:0] ea);
    checks++;
    if (bus.imem_read !== er || (er && bus.imem_address !== ea)) begin
      errors++;
      $display("FAIL %s req got %b@%h exp %b@%h", name, bus.imem_read, bus.imem_address, er, ea);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0 || pc_plus_4 !== 32'h0 || instruction !== NOP || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out got %h %h %h %b", pc, pc_plus_4, instruction, fetch_valid);
    end
    expect_req("reset_req", 1'b0, 32'h0);
    reset = 1'b0;
    #1;
    expect_req("idle_req", 1'b0, 32'h0);
    step();
    expect_req("fetch0_req", 1'b1, 32'h0);
    checks++;
    if (fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL cycle2_valid got %b exp 0", fetch_valid);
    end
    step();
    expect_out("seq0", 32'h0, 1'b1);
    expect_req("seq0_req", 1'b1, 32'h4);
    step();
    expect_out("seq4", 32'h4, 1'b1);
    expect_req("seq4_req", 1'b1, 32'h8);
  endtask

  task automatic test_busywait();
    busy = 1'b1;
    step();
    expect_out("busy_bubble1", 32'h4, 1'b0);
    expect_req("busy_req1", 1'b1, 32'h8);
    step();
    expect_out("busy_bubble2", 32'h4, 1'b0);
    expect_req("busy_req2", 1'b1, 32'h8);
    busy = 1'b0;
    step();
    expect_out("busy_done", 32'h8, 1'b1);
    expect_req("busy_next", 1'b1, 32'hC);
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      expect_out("stall_frozen", 32'h8, 1'b1);
      expect_req("stall_hold_req", 1'b0, 32'h0);
    end
    stall = 1'b0;
    step();
    expect_out("stall_release", 32'hC, 1'b1);
    expect_req("stall_release_req", 1'b1, 32'h10);
    step();
    expect_out("stall_next", 32'h10, 1'b1);
  endtask

  task automatic run_to_addr8();
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    step();
    step();
    expect_req("rerun_req", 1'b1, 32'h8);
  endtask

  task automatic test_branch_drain();
    run_to_addr8();
    busy = 1'b1;
    step();
    branch_taken = 1'b1;
    branch_target = 32'h103;
    step();
    branch_taken = 1'b0;
    expect_out("drain_bubble", 32'h4, 1'b0);
    expect_req("drain_req", 1'b1, 32'h8);
    step();
    expect_req("drain_req2", 1'b1, 32'h8);
    busy = 1'b0;
    step();
    expect_out("drain_discard", 32'h4, 1'b0);
    expect_req("drain_redirect", 1'b1, 32'h100);
    step();
    expect_out("drain_target", 32'h100, 1'b1);
  endtask

  task automatic test_branch_fast();
    branch_taken = 1'b1;
    branch_target = 32'h200;
    step();
    branch_taken = 1'b0;
    expect_out("fast_bubble", 32'h100, 1'b0);
    expect_req("fast_req", 1'b1, 32'h200);
    step();
    expect_out("fast_target", 32'h200, 1'b1);
  endtask

  task automatic test_reset_in_drain();
    busy = 1'b1;
    branch_taken = 1'b1;
    branch_target = 32'h300;
    step();
    branch_taken = 1'b0;
    expect_req("rd_drain_req", 1'b1, 32'h204);
    stall = 1'b1;
    reset = 1'b1;
    step();
    checks++;
    if (pc !== 32'h0 || pc_plus_4 !== 32'h0 || instruction !== NOP || fetch_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_reset_out got %h %h %h %b", pc, pc_plus_4, instruction, fetch_valid);
    end
    expect_req("rd_reset_req", 1'b0, 32'h0);
    reset = 1'b0;
    stall = 1'b0;
    busy = 1'b0;
    step();
    expect_req("rd_resume_req", 1'b1, 32'h0);
    step();
    expect_out("rd_resume", 32'h0, 1'b1);
  endtask

  task automatic test_wrap();
    logic [31:0] exp_pc [3];
    exp_pc[0] = 32'hFFFF_FFF8;
    exp_pc[1] = 32'hFFFF_FFFC;
    exp_pc[2] = 32'h0000_0000;
    reset2 = 1'b1;
    step();
    reset2 = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (fetch_valid2 !== 1'b1 || pc2 !== exp_pc[i] || pc_plus_4_2 !== exp_pc[i] + 32'd4 ||
          instruction2 !== (exp_pc[i] ^ KEY)) begin
        errors++;
        $display("FAIL wrap%0d got %b %h %h %h exp pc %h", i, fetch_valid2, pc2,
                 pc_plus_4_2, instruction2, exp_pc[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_busywait();
    test_stall();
    test_branch_drain();
    test_branch_fast();
    test_reset_in_drain();
    test_wrap();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
